// File: rtl/syst_pkg.sv
// Shared sizing and types for the systolic-array front end.
package syst_pkg;
    localparam int LANES = 5;   // array rows fed by the skew feeder
    localparam int DW    = 8;   // activation width per lane
    localparam int YW    = 20;  // syst_ws accumulator output width

    // One activation row; lane k sits in element k (lane 0 = x1).
    typedef logic [LANES-1:0][DW-1:0] row_t;
endpackage

// File: rtl/syst_row_fifo.sv
// Row FIFO: power-of-two depth, free-running wrap pointers, occupancy count.
module syst_row_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    // Flush wins over both ports so a same-cycle push is dropped.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign rdata_o = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + (AW+1)'(1);
                2'b01:   count_o <= count_o - (AW+1)'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end
endmodule

// File: rtl/syst_skew_feeder.sv
// Buffers activation rows and skews them diagonally into the systolic array:
// lane k sees each row k cycles after lane 0.
module syst_skew_feeder #(
    parameter int LANES = syst_pkg::LANES,
    parameter int DW    = syst_pkg::DW,
    parameter int DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                row_valid_i,
    input  logic [LANES*DW-1:0] row_data_i,
    output logic                row_ready_o,
    input  logic                flush_i,
    output logic [DW-1:0]       x1_o,
    output logic [DW-1:0]       x2_o,
    output logic [DW-1:0]       x3_o,
    output logic [DW-1:0]       x4_o,
    output logic [DW-1:0]       x5_o,
    output logic                valid1_o,
    output logic                valid2_o,
    output logic                valid3_o,
    output logic                valid4_o,
    output logic                valid5_o,
    output logic                busy_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [LANES-1:0][DW-1:0] head;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;
    logic                     pop;
    logic                     rdy_en_q;
    logic [LANES-1:0][DW-1:0] x_lane;
    logic [LANES-1:0]         v_lane;
    logic [LANES-1:0]         lane_busy;

    // Holds ready low through reset and releases it on the first edge after.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    assign row_ready_o = rdy_en_q & ~full & ~flush_i;
    // The array never back-pressures, so drain the head every cycle it exists.
    assign pop         = ~empty;

    syst_row_fifo #(
        .W     (LANES*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (row_valid_i & row_ready_o),
        .pop_i   (pop),
        .wdata_i (row_data_i),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Triangular skew line: lane k owns k+1 private stages.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [k:0]         vld_pipe;
        logic [k:0][DW-1:0] dat_pipe;

        // Stage 0 captures the popped byte; data is zeroed whenever invalid.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                vld_pipe <= '0;
                dat_pipe <= '0;
            end else if (flush_i) begin
                vld_pipe <= '0;
                dat_pipe <= '0;
            end else begin
                vld_pipe[0] <= pop;
                dat_pipe[0] <= pop ? head[k] : '0;
                for (int j = 1; j <= k; j++) begin
                    vld_pipe[j] <= vld_pipe[j-1];
                    dat_pipe[j] <= dat_pipe[j-1];
                end
            end
        end

        assign x_lane[k]    = dat_pipe[k];
        assign v_lane[k]    = vld_pipe[k];
        assign lane_busy[k] = |vld_pipe;
    end

    assign x1_o     = x_lane[0];
    assign x2_o     = x_lane[1];
    assign x3_o     = x_lane[2];
    assign x4_o     = x_lane[3];
    assign x5_o     = x_lane[4];
    assign valid1_o = v_lane[0];
    assign valid2_o = v_lane[1];
    assign valid3_o = v_lane[2];
    assign valid4_o = v_lane[3];
    assign valid5_o = v_lane[4];
    assign busy_o   = (count != '0) | (|lane_busy);
endmodule

// File: tb/tb_syst_skew_feeder.sv
// Bench for syst_skew_feeder: directed wavefronts plus random traffic,
// scored against a queue/history model of the feeder's behaviour.
module tb_syst_skew_feeder;
    import syst_pkg::*;

    localparam int DEPTH = 4;
    typedef logic [LANES*DW-1:0] flat_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          row_valid_i;
    flat_t         row_data_i;
    logic          row_ready_o;
    logic          flush_i;
    logic [DW-1:0] x1_o, x2_o, x3_o, x4_o, x5_o;
    logic          valid1_o, valid2_o, valid3_o, valid4_o, valid5_o;
    logic          busy_o;

    syst_skew_feeder #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .row_valid_i (row_valid_i),
        .row_data_i  (row_data_i),
        .row_ready_o (row_ready_o),
        .flush_i     (flush_i),
        .x1_o        (x1_o),
        .x2_o        (x2_o),
        .x3_o        (x3_o),
        .x4_o        (x4_o),
        .x5_o        (x5_o),
        .valid1_o    (valid1_o),
        .valid2_o    (valid2_o),
        .valid3_o    (valid3_o),
        .valid4_o    (valid4_o),
        .valid5_o    (valid5_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: accepted rows waiting in a queue, plus the history of which row
    // left the queue at each of the last LANES edges (hv[j]/hd[j] = j edges ago).
    // Lane k shows the row popped k edges ago.
    flat_t          q[$];
    logic [LANES-1:0] hv;
    flat_t          hd [LANES];
    bit             rdy_en;

    function automatic logic [DW-1:0] lane_byte(flat_t r, int k);
        return r[k*DW +: DW];
    endfunction

    task automatic check_outs(string ph);
        row_t             xs;
        logic [LANES-1:0] vs;
        xs = {x5_o, x4_o, x3_o, x2_o, x1_o};
        vs = {valid5_o, valid4_o, valid3_o, valid2_o, valid1_o};
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("%s valid%0d", ph, k+1), 64'(vs[k]), 64'(hv[k]));
            check($sformatf("%s x%0d", ph, k+1), 64'(xs[k]),
                  64'(hv[k] ? lane_byte(hd[k], k) : '0));
        end
        check($sformatf("%s busy", ph), 64'(busy_o), 64'((q.size() != 0) || (hv != '0)));
    endtask

    // One clock cycle: drive, check ready, advance model at the edge, check outputs.
    task automatic step(bit v, flat_t d, bit f);
        bit    r_exp;
        bit    pv;
        flat_t pd;
        row_valid_i = v;
        row_data_i  = d;
        flush_i     = f;
        #1;
        r_exp = rdy_en && (q.size() < DEPTH) && !f;
        check("ready", 64'(row_ready_o), 64'(r_exp));
        @(posedge clk);
        if (f) begin
            q.delete();
            hv = '0;
        end else begin
            pv = (q.size() != 0);
            pd = '0;
            if (pv) pd = q.pop_front();
            for (int j = LANES-1; j > 0; j--) begin
                hv[j] = hv[j-1];
                hd[j] = hd[j-1];
            end
            hv[0] = pv;
            hd[0] = pd;
            if (v && r_exp) q.push_back(d);
        end
        rdy_en = 1'b1;
        #1;
        check_outs("step");
    endtask

    // Asynchronous reset mid-cycle; everything in flight is discarded.
    task automatic reset_pulse();
        rst_i       = 1'b0;
        row_valid_i = 1'b1;
        flush_i     = 1'b0;
        #1;
        q.delete();
        hv     = '0;
        rdy_en = 1'b0;
        check("rst ready", 64'(row_ready_o), 64'(0));
        check_outs("rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst hold ready", 64'(row_ready_o), 64'(0));
        check_outs("rst hold");
        #2;
        rst_i       = 1'b1;
        row_valid_i = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        rst_i       = 1'b0;
        row_valid_i = 1'b0;
        row_data_i  = '0;
        flush_i     = 1'b0;
        hv          = '0;
        rdy_en      = 1'b0;
        for (int k = 0; k < LANES; k++) hd[k] = '0;
        #1;
        check("por ready", 64'(row_ready_o), 64'(0));
        check_outs("por");
        @(posedge clk);
        #3 rst_i = 1'b1;

        // ready comes up on the first edge after release
        step(0, '0, 0);

        // single wavefront 1..5
        step(1, 40'h05_04_03_02_01, 0);
        repeat (6) step(0, '0, 0);

        // three back-to-back rows
        step(1, {5{8'h11}}, 0);
        step(1, {5{8'h22}}, 0);
        step(1, {5{8'h33}}, 0);
        repeat (8) step(0, '0, 0);

        // valid held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            r64 = {$urandom, $urandom};
            step(1, r64[39:0], 0);
        end
        repeat (6) step(0, '0, 0);

        // flush with rows in flight and a push in the same cycle
        step(1, {5{8'hA1}}, 0);
        step(1, {5{8'hA2}}, 0);
        step(1, {5{8'hA3}}, 0);
        step(1, {5{8'hEE}}, 1);
        repeat (6) step(0, '0, 0);

        // reset between lanes 2 and 3 of a wavefront
        step(1, 40'h55_44_33_22_11, 0);
        repeat (3) step(0, '0, 0);
        reset_pulse();
        repeat (7) step(0, '0, 0);

        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) reset_pulse();
            step($urandom_range(0, 9) < 7, r64[39:0], $urandom_range(0, 39) == 0);
        end
        repeat (6) step(0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
